// File: rtl/tmr_counter8.sv
// rtl/tmr_counter8.sv - 8-bit up-counter with triple modular redundancy
// Three replicas feed a bitwise 2-of-3 voter whose result is written back to all of them.
module tmr_counter8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] q_out
);

    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] cnt_a;
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] cnt_b;
    (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] cnt_c;

    logic [WIDTH-1:0] w_voted;
    logic [WIDTH-1:0] w_next;

    assign w_voted = (cnt_a & cnt_b) | (cnt_a & cnt_c) | (cnt_b & cnt_c);
    assign w_next  = enable ? w_voted + WIDTH'(1) : w_voted;
    assign q_out   = w_voted;

    // Reloading from the voted value every edge scrubs a single upset replica.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
        end else begin
            cnt_a <= w_next;
            cnt_b <= w_next;
            cnt_c <= w_next;
        end
    end

endmodule

// File: tb/tb_tmr_counter8.sv
// tb/tb_tmr_counter8.sv - scoreboard bench for the TMR counter
module tb_tmr_counter8;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] q_out;

    logic [7:0] m;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int         vectors;
    int         miscompares;

    tmr_counter8 #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .q_out  (q_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, push the model's expected count, wait until after the edge.
    task automatic step(input logic en, input logic r);
        @(negedge clk);
        enable = en;
        rst    = r;
        if (r)       m = 8'h00;
        else if (en) m = m + 8'h01;
        exp_q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (q_out !== e) begin
            $display("FAIL reset_q: got %h expected %h", q_out, e);
            miscompares++;
        end
        vectors++;
        if (dut.cnt_a !== 8'h00 || dut.cnt_b !== 8'h00 || dut.cnt_c !== 8'h00) begin
            $display("FAIL reset_replicas: got %h %h %h expected 00 00 00",
                     dut.cnt_a, dut.cnt_b, dut.cnt_c);
            miscompares++;
        end
    endtask

    task automatic test_count(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            e = exp_q.pop_front();
            vectors++;
            if (q_out !== e) begin
                $display("FAIL %s[%0d]: got %h expected %h", name, i, q_out, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_hold(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0);
            e = exp_q.pop_front();
            vectors++;
            if (q_out !== e) begin
                $display("FAIL hold[%0d]: got %h expected %h", i, q_out, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_fault(input logic en, input logic use_b);
        @(negedge clk);
        enable = en;
        rst    = 1'b0;
        if (use_b) force dut.cnt_b = 8'h80;
        else       force dut.cnt_a = 8'h80;
        #1;
        vectors++;
        if (q_out !== m) begin
            $display("FAIL fault_masked: got %h expected %h", q_out, m);
            miscompares++;
        end
        if (use_b) release dut.cnt_b;
        else       release dut.cnt_a;
        if (en) m = m + 8'h01;
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (q_out !== e) begin
            $display("FAIL fault_next: got %h expected %h", q_out, e);
            miscompares++;
        end
        vectors++;
        if (dut.cnt_a !== e || dut.cnt_b !== e || dut.cnt_c !== e) begin
            $display("FAIL fault_scrub: got %h %h %h expected %h",
                     dut.cnt_a, dut.cnt_b, dut.cnt_c, e);
            miscompares++;
        end
    endtask

    task automatic test_wrap();
        test_reset();
        test_count(254, "preload");
        vectors++;
        if (q_out !== 8'hFE) begin
            $display("FAIL wrap_preload: got %h expected fe", q_out);
            miscompares++;
        end
        test_count(3, "wrap");
        vectors++;
        if (q_out !== 8'h01) begin
            $display("FAIL wrap_end: got %h expected 01", q_out);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        test_count(4, "to_five");
        step(1'b1, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (q_out !== e) begin
            $display("FAIL reset_mid: got %h expected %h", q_out, e);
            miscompares++;
        end
        test_count(2, "after_reset");
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        m           = 8'h00;
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_count(8, "count");
        test_hold(6);
        test_fault(1'b0, 1'b1);
        test_count(15, "resume");
        vectors++;
        if (q_out !== 8'd23) begin
            $display("FAIL resume_end: got %0d expected 23", q_out);
            miscompares++;
        end
        test_fault(1'b1, 1'b0);
        test_wrap();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
